// File: rtl/fetch_queue.sv
// fetch_queue: fetch-stage consumer of PC_F. It issues one instruction-memory
// request at a time over a req/ack port and queues {PC, instr} pairs for decode.
// Stall_F holds the PC until a fetch launches. Redirect flushes the queue and
// drops any in-flight wrong-path fetch.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC_F,
  output logic        Stall_F,
  input  logic        Redirect,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ack,
  input  logic [31:0] IM_RData,
  input  logic        Stall_D,
  output logic        Valid_D,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t                 state_q, state_d;
  logic                   im_req_q, im_req_d;
  logic [31:0]            addr_q, addr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW:0]            count_q, count_d;
  entry_t [DEPTH-1:0]     mem_q, mem_d;

  logic full;
  logic issue;
  logic push;
  logic pop;

  // Space is reserved at issue, so a push that follows can never overflow.
  assign full = (count_q == FULL_CNT);

  // FSM state register; reset returns to IDLE, abandoning any outstanding request.
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: one outstanding request; DROP waits out a wrong-path ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!Redirect && !full) state_d = S_WAIT;
      S_WAIT: begin
        if (IM_Ack)        state_d = S_IDLE;
        else if (Redirect) state_d = S_DROP;
      end
      S_DROP: if (IM_Ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: PC release, request launch and queue push decisions.
  always_comb begin
    Stall_F = 1'b1;
    issue   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        issue   = !Redirect && !full;
        Stall_F = !(Redirect || !full);
      end
      S_WAIT: begin
        Stall_F = !Redirect;
        push    = IM_Ack && !Redirect;
      end
      S_DROP: Stall_F = !Redirect;
      default: ;
    endcase
    if (!RESET) begin
      Stall_F = 1'b1;
      issue   = 1'b0;
      push    = 1'b0;
    end
  end

  // Request port and queue next-state; Redirect wins over any push or pop.
  always_comb begin
    pop      = (count_q != '0) && !Stall_D && !Redirect;
    im_req_d = im_req_q;
    addr_d   = addr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (issue) begin
      im_req_d = 1'b1;
      addr_d   = PC_F;
    end else if (state_q != S_IDLE && IM_Ack) begin
      im_req_d = 1'b0;
    end

    if (Redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: addr_q, instr: IM_RData};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Datapath registers; storage resets so the empty head shows RESET_PC / 0.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      im_req_q <= 1'b0;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: RESET_PC, instr: 32'h0};
    end else begin
      im_req_q <= im_req_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign IM_Req  = im_req_q;
  assign IM_Addr = addr_q;
  assign Valid_D = (count_q != '0);
  assign Instr_D = mem_q[rd_ptr_q].instr;
  assign PC_D    = mem_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors for fetch_queue with hand-computed expectations.
// The bench plays the PC register (advances on !Stall_F, loads tgt on Redirect)
// and the instruction memory (acks driven explicitly per cycle).
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        Redirect = 1'b0;
  logic        IM_Ack = 1'b0;
  logic        Stall_D = 1'b0;
  logic [31:0] PC_F = 32'h3000;
  logic [31:0] IM_RData = 32'h0;
  logic [31:0] tgt = 32'h0;
  logic        Stall_F, IM_Req, Valid_D;
  logic [31:0] IM_Addr, Instr_D, PC_D;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .CLK(CLK), .RESET(RESET), .PC_F(PC_F), .Stall_F(Stall_F), .Redirect(Redirect),
    .IM_Req(IM_Req), .IM_Addr(IM_Addr), .IM_Ack(IM_Ack), .IM_RData(IM_RData),
    .Stall_D(Stall_D), .Valid_D(Valid_D), .Instr_D(Instr_D), .PC_D(PC_D)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock: PC model updates from the values seen at the edge; pulses clear.
  task automatic step();
    logic adv, rd;
    adv = RESET && !Stall_F;
    rd  = Redirect;
    @(posedge CLK); #1;
    if (adv) PC_F = rd ? tgt : PC_F + 32'd4;
    IM_Ack   = 1'b0;
    Redirect = 1'b0;
    #1;
  endtask

  task automatic do_reset(input logic sd);
    RESET = 1'b0; Redirect = 1'b0; IM_Ack = 1'b0; Stall_D = sd;
    step(); step();
    RESET = 1'b1; PC_F = 32'h3000; #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // reset state
    RESET = 1'b0; #1;
    step();
    chk("rst_stallf", 32'(Stall_F), 32'd1);
    chk("rst_req",    32'(IM_Req),  32'd0);
    chk("rst_valid",  32'(Valid_D), 32'd0);
    chk("rst_pcd",    PC_D,         32'h3000);
    chk("rst_instr",  Instr_D,      32'h0);

    // 1: 1-cycle ack, no decode stall
    do_reset(1'b0);
    chk("s1_idle_stallf", 32'(Stall_F), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("s1_req",         32'(IM_Req),  32'd1);
      chk("s1_addr",        IM_Addr,      32'h3000 + 32'(4*i));
      chk("s1_wait_stallf", 32'(Stall_F), 32'd1);
      IM_Ack = 1'b1; IM_RData = 32'hA000_0000 + 32'(i); #1;
      step();
      chk("s1_valid",       32'(Valid_D), 32'd1);
      chk("s1_pcd",         PC_D,         32'h3000 + 32'(4*i));
      chk("s1_instr",       Instr_D,      32'hA000_0000 + 32'(i));
      chk("s1_idle_stallf", 32'(Stall_F), 32'd0);
      step();
      chk("s1_popped",      32'(Valid_D), 32'd0);
    end

    // 2: decode stalled, queue fills to DEPTH, further fetches blocked
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("s2_issue", 32'(Stall_F), 32'd0);
      step();
      IM_Ack = 1'b1; IM_RData = 32'hB000_0000 + 32'(i); #1;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk("s2_full_stallf", 32'(Stall_F), 32'd1);
      chk("s2_full_req",    32'(IM_Req),  32'd0);
      chk("s2_full_head",   PC_D,         32'h3000);
      step();
    end
    // 2/5: drain in order with push+pop overlap and pointer wrap
    Stall_D = 1'b0; #1;
    chk("s2_drain0_pc",     PC_D,         32'h3000);
    chk("s2_drain0_stallf", 32'(Stall_F), 32'd1);
    step();
    chk("s2_drain1_pc",     PC_D,         32'h3004);
    chk("s2_resume_stallf", 32'(Stall_F), 32'd0);
    step();
    chk("s5_addr0",  IM_Addr, 32'h3010);
    chk("s5_pc0",    PC_D,    32'h3008);
    IM_Ack = 1'b1; IM_RData = 32'hB000_0004; #1;
    step();
    chk("s5_pc1",    PC_D,    32'h300C);
    chk("s5_instr1", Instr_D, 32'hB000_0003);
    step();
    chk("s5_addr1",  IM_Addr, 32'h3014);
    chk("s5_pc2",    PC_D,    32'h3010);
    chk("s5_instr2", Instr_D, 32'hB000_0004);
    IM_Ack = 1'b1; IM_RData = 32'hB000_0005; #1;
    step();
    chk("s5_pc3",    PC_D,    32'h3014);
    chk("s5_instr3", Instr_D, 32'hB000_0005);
    chk("s5_valid",  32'(Valid_D), 32'd1);

    // 3: redirect in WAIT, second redirect in DROP, ack 3 cycles later
    do_reset(1'b0);
    step();
    Redirect = 1'b1; tgt = 32'h5000; #1;
    chk("s3_redir_stallf", 32'(Stall_F), 32'd0);
    step();
    chk("s3_drop_stallf", 32'(Stall_F), 32'd1);
    chk("s3_drop_req",    32'(IM_Req),  32'd1);
    chk("s3_drop_addr",   IM_Addr,      32'h3000);
    Redirect = 1'b1; tgt = 32'h6000; #1;
    chk("s3_drop_redir_stallf", 32'(Stall_F), 32'd0);
    step();
    chk("s3_drop2_stallf", 32'(Stall_F), 32'd1);
    step();
    IM_Ack = 1'b1; IM_RData = 32'hDEAD_BEEF; #1;
    chk("s3_ack_stallf", 32'(Stall_F), 32'd1);
    step();
    chk("s3_discard_valid", 32'(Valid_D), 32'd0);
    chk("s3_idle_req",      32'(IM_Req),  32'd0);
    chk("s3_idle_stallf",   32'(Stall_F), 32'd0);
    step();
    chk("s3_new_addr", IM_Addr,      32'h6000);
    chk("s3_new_req",  32'(IM_Req),  32'd1);

    // 4: redirect coincident with ack and pop
    do_reset(1'b1);
    step();
    IM_Ack = 1'b1; IM_RData = 32'hC000_0000; #1;
    step();
    step();
    chk("s4_pre_valid", 32'(Valid_D), 32'd1);
    chk("s4_pre_addr",  IM_Addr,      32'h3004);
    Stall_D = 1'b0; Redirect = 1'b1; tgt = 32'h7000;
    IM_Ack = 1'b1; IM_RData = 32'hC000_0001; #1;
    chk("s4_stallf", 32'(Stall_F), 32'd0);
    step();
    chk("s4_flush_valid", 32'(Valid_D), 32'd0);
    chk("s4_flush_req",   32'(IM_Req),  32'd0);
    chk("s4_idle_stallf", 32'(Stall_F), 32'd0);
    step();
    chk("s4_new_addr",  IM_Addr,      32'h7000);
    chk("s4_still_emp", 32'(Valid_D), 32'd0);

    // 6: reset during WAIT, stray ack afterwards
    do_reset(1'b1);
    step();
    IM_Ack = 1'b1; IM_RData = 32'hD000_0000; #1;
    step();
    step();
    chk("s6_pre_valid", 32'(Valid_D), 32'd1);
    chk("s6_pre_req",   32'(IM_Req),  32'd1);
    RESET = 1'b0; #1;
    chk("s6_rst_stallf", 32'(Stall_F), 32'd1);
    step();
    chk("s6_req",   32'(IM_Req),  32'd0);
    chk("s6_valid", 32'(Valid_D), 32'd0);
    chk("s6_pcd",   PC_D,         32'h3000);
    chk("s6_instr", Instr_D,      32'h0);
    RESET = 1'b1; PC_F = 32'h3000; IM_Ack = 1'b1; IM_RData = 32'h0000_0BAD; #1;
    step();
    chk("s6_stray_valid", 32'(Valid_D), 32'd0);
    chk("s6_new_req",     32'(IM_Req),  32'd1);
    chk("s6_new_addr",    IM_Addr,      32'h3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
